// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key event scheduler: slot states,
// keycode width, the default arrow/space bindings and counter sizing.
package key_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } slot_state_t;

    localparam int KEY_W = 9;

    localparam logic [KEY_W-1:0] KEY_LEFT  = 9'h06B;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 9'h074;
    localparam logic [KEY_W-1:0] KEY_UP    = 9'h075;
    localparam logic [KEY_W-1:0] KEY_SPACE = 9'h029;

    // Counter only ever holds values up to max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_repeat_slot.sv
// Typematic state machine for one binding slot: press event on make, first
// repeat after INITIAL_DELAY, then one repeat every REPEAT_PERIOD cycles.
module key_repeat_slot #(
    parameter int KEY_W         = key_sched_pkg::KEY_W,
    parameter int INITIAL_DELAY = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [KEY_W-1:0] key_code,
    input  logic             make,
    input  logic             brakee,
    input  logic [KEY_W-1:0] slot_code,
    input  logic             clear,
    output logic             key_pressed,
    output logic             set_pend,
    output logic             set_rep
);
    import key_sched_pkg::*;

    localparam int               CNT_W       = cnt_width(INITIAL_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(INITIAL_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    slot_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             hit_s;

    assign hit_s       = (key_code == slot_code);
    assign key_pressed = pressed_q;

    // Next-state, counter and event-request logic; break beats make.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        set_pend  = 1'b0;
        set_rep   = 1'b0;
        if (clear || (brakee && hit_s)) begin
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            pressed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (make && hit_s) begin
                        state_d   = DELAY;
                        cnt_d     = DELAY_LOAD;
                        pressed_d = 1'b1;
                        set_pend  = 1'b1;
                        set_rep   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DELAY, REPEAT: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d  = REPEAT;
                        cnt_d    = REPEAT_LOAD;
                        set_pend = 1'b1;
                        set_rep  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    pressed_d = 1'b0;
                end
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Binding table, per-slot typematic engines and a round-robin arbiter that
// serialises their press/repeat events onto one valid/ready channel.
module key_event_scheduler #(
    parameter int               NUM_KEYS      = 4,
    parameter int               KEY_W         = key_sched_pkg::KEY_W,
    parameter int               INITIAL_DELAY = 25000000,
    parameter int               REPEAT_PERIOD = 5000000,
    parameter logic [KEY_W-1:0] DEFAULT_CODES [NUM_KEYS] = '{key_sched_pkg::KEY_LEFT,
                                                             key_sched_pkg::KEY_RIGHT,
                                                             key_sched_pkg::KEY_SPACE,
                                                             key_sched_pkg::KEY_UP},
    localparam int              IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [KEY_W-1:0]    keyCode,
    input  logic                make,
    input  logic                brakee,
    input  logic                enable,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [KEY_W-1:0]    cfg_code,
    output logic [NUM_KEYS-1:0] keyPressed,
    output logic                evt_valid,
    output logic [IDX_W-1:0]    evt_idx,
    output logic                evt_repeat,
    input  logic                evt_ready,
    output logic [7:0]          drop_cnt
);
    import key_sched_pkg::*;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

    logic [KEY_W-1:0]    bind_q [NUM_KEYS];
    logic [KEY_W-1:0]    bind_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic [NUM_KEYS-1:0] pend_rep_q, pend_rep_d;
    logic                lock_q, lock_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic [NUM_KEYS-1:0] slot_set_s, slot_rep_s, cfg_hit_s, slot_clr_s;
    logic [IDX_W-1:0]    grant_s, cand_s;
    logic                found_s, handshake_s;
    logic [4:0]          drop_n_s;
    logic [8:0]          drop_sum_s;
    int                  scan_s;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
        key_repeat_slot #(
            .KEY_W         (KEY_W),
            .INITIAL_DELAY (INITIAL_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_slot (
            .clk         (clk),
            .resetN      (resetN),
            .key_code    (keyCode),
            .make        (make),
            .brakee      (brakee),
            .slot_code   (bind_q[i]),
            .clear       (cfg_hit_s[i]),
            .key_pressed (keyPressed[i]),
            .set_pend    (slot_set_s[i]),
            .set_rep     (slot_rep_s[i])
        );
    end

    assign evt_valid   = lock_q | (|pending_q);
    assign evt_idx     = grant_s;
    assign evt_repeat  = pend_rep_q[grant_s];
    assign drop_cnt    = drop_cnt_q;
    assign handshake_s = evt_valid & evt_ready;

    // Decode which slot a configuration write targets.
    always_comb begin
        cfg_hit_s = {NUM_KEYS{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            cfg_hit_s[i] = cfg_we && (cfg_idx == IDX_W'(i));
        end
    end

    // Round-robin grant: a locked grant is held, otherwise scan from rr_q.
    always_comb begin
        grant_s = rr_q;
        found_s = 1'b0;
        cand_s  = IDX_ZERO;
        scan_s  = 0;
        if (lock_q) begin
            grant_s = grant_q;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                scan_s = int'(rr_q) + k;
                scan_s = (scan_s >= NUM_KEYS) ? scan_s - NUM_KEYS : scan_s;
                cand_s = IDX_W'(scan_s);
                if (!found_s && pending_q[cand_s]) begin
                    grant_s = cand_s;
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Pending/type bookkeeping, coalescing count, lock and pointer update.
    always_comb begin
        bind_d     = bind_q;
        pending_d  = pending_q;
        pend_rep_d = pend_rep_q;
        slot_clr_s = {NUM_KEYS{1'b0}};
        drop_n_s   = 5'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            slot_clr_s[i] = handshake_s && (grant_s == IDX_W'(i));
            if (cfg_hit_s[i]) begin
                bind_d[i] = cfg_code;
            end else begin
                bind_d[i] = bind_q[i];
            end
            if (!enable || cfg_hit_s[i]) begin
                pending_d[i] = 1'b0;
            end else if (slot_set_s[i]) begin
                // A set racing the consumer's clear re-arms the bit without a drop.
                pending_d[i]  = 1'b1;
                pend_rep_d[i] = slot_rep_s[i];
                if (pending_q[i] && !slot_clr_s[i]) begin
                    drop_n_s = drop_n_s + 5'd1;
                end else begin
                    drop_n_s = drop_n_s;
                end
            end else if (slot_clr_s[i]) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end

        drop_sum_s = {1'b0, drop_cnt_q} + {4'b0000, drop_n_s};
        drop_cnt_d = (drop_sum_s > 9'd255) ? 8'hFF : drop_sum_s[7:0];

        lock_d  = 1'b0;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (!enable) begin
            lock_d = 1'b0;
        end else if (handshake_s) begin
            lock_d = 1'b0;
            rr_d   = (grant_s == IDX_LAST) ? IDX_ZERO : grant_s + IDX_ONE;
        end else if (evt_valid && !cfg_hit_s[grant_s]) begin
            lock_d  = 1'b1;
            grant_d = grant_s;
        end else begin
            lock_d = 1'b0;
        end
    end

    // Table and arbiter state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                bind_q[i] <= DEFAULT_CODES[i];
            end
            pending_q  <= {NUM_KEYS{1'b0}};
            pend_rep_q <= {NUM_KEYS{1'b0}};
            lock_q     <= 1'b0;
            grant_q    <= IDX_ZERO;
            rr_q       <= IDX_ZERO;
            drop_cnt_q <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                bind_q[i] <= bind_d[i];
            end
            pending_q  <= pending_d;
            pend_rep_q <= pend_rep_d;
            lock_q     <= lock_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with short typematic timing
// (press-to-repeat 8 cycles, repeat period 4 cycles).
module tb_key_event_scheduler;

    logic       clk = 1'b0;
    logic       resetN;
    logic [8:0] keyCode;
    logic       make;
    logic       brakee;
    logic       enable;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [8:0] cfg_code;
    logic [3:0] keyPressed;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_repeat;
    logic       evt_ready;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_event_scheduler #(
        .NUM_KEYS      (4),
        .KEY_W         (9),
        .INITIAL_DELAY (8),
        .REPEAT_PERIOD (4)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .keyCode    (keyCode),
        .make       (make),
        .brakee     (brakee),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_code   (cfg_code),
        .keyPressed (keyPressed),
        .evt_valid  (evt_valid),
        .evt_idx    (evt_idx),
        .evt_repeat (evt_repeat),
        .evt_ready  (evt_ready),
        .drop_cnt   (drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input logic [8:0] code);
        keyCode = code;
        make    = 1'b1;
        tick(1);
        make    = 1'b0;
    endtask

    task automatic break_key(input logic [8:0] code);
        keyCode = code;
        brakee  = 1'b1;
        tick(1);
        brakee  = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [8:0] code);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_code = code;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    initial begin
        resetN    = 1'b0;
        keyCode   = 9'h000;
        make      = 1'b0;
        brakee    = 1'b0;
        enable    = 1'b1;
        cfg_we    = 1'b0;
        cfg_idx   = 2'd0;
        cfg_code  = 9'h000;
        evt_ready = 1'b1;
        tick(2);
        check_eq("rst_valid", evt_valid, 1'b0);
        check_eq("rst_held", keyPressed, 4'b0000);
        check_eq("rst_drop", drop_cnt, 8'd0);
        check_eq("rst_idx", evt_idx, 2'd0);
        check_eq("rst_rep", evt_repeat, 1'b0);
        resetN = 1'b1;
        tick(2);

        // Single key: press, repeats at +8, +12, break before the third.
        press_key(9'h06B);
        check_eq("press_valid", evt_valid, 1'b1);
        check_eq("press_idx", evt_idx, 2'd0);
        check_eq("press_rep", evt_repeat, 1'b0);
        check_eq("press_held", keyPressed, 4'b0001);
        tick(1);
        check_eq("press_taken", evt_valid, 1'b0);
        tick(7);
        check_eq("rep1_valid", evt_valid, 1'b1);
        check_eq("rep1_idx", evt_idx, 2'd0);
        check_eq("rep1_rep", evt_repeat, 1'b1);
        tick(1);
        check_eq("rep1_gap", evt_valid, 1'b0);
        tick(3);
        check_eq("rep2_valid", evt_valid, 1'b1);
        check_eq("rep2_rep", evt_repeat, 1'b1);
        tick(2);
        break_key(9'h06B);
        check_eq("brk_held", keyPressed, 4'b0000);
        check_eq("brk_valid16", evt_valid, 1'b0);
        tick(1);
        check_eq("brk_no_rep", evt_valid, 1'b0);

        // Move rr to 0 via a slot-3 event, then alias slot 2 onto 06B.
        press_key(9'h075);
        check_eq("up_idx", evt_idx, 2'd3);
        break_key(9'h075);
        cfg_write(2'd2, 9'h06B);
        evt_ready = 1'b0;
        press_key(9'h06B);
        check_eq("dual_valid", evt_valid, 1'b1);
        check_eq("dual_idx_c1", evt_idx, 2'd0);
        check_eq("dual_held", keyPressed, 4'b0101);
        tick(4);
        check_eq("dual_idx_c5", evt_idx, 2'd0);
        tick(1);
        evt_ready = 1'b1;
        check_eq("dual_idx_c6", evt_idx, 2'd0);
        tick(1);
        check_eq("dual_idx_c7", evt_idx, 2'd2);
        check_eq("dual_rep_c7", evt_repeat, 1'b0);
        tick(1);
        check_eq("dual_idle_c8", evt_valid, 1'b0);
        tick(1);
        check_eq("wrap_idx_c9", evt_idx, 2'd0);
        check_eq("wrap_rep_c9", evt_repeat, 1'b1);
        tick(1);
        check_eq("wrap_idx_c10", evt_idx, 2'd2);
        check_eq("wrap_valid_c10", evt_valid, 1'b1);
        tick(1);
        check_eq("dual_idle_c11", evt_valid, 1'b0);
        break_key(9'h06B);
        check_eq("dual_released", keyPressed, 4'b0000);
        tick(1);
        check_eq("dual_no_rep", evt_valid, 1'b0);
        cfg_write(2'd2, 9'h029);

        // Stalled consumer: repeats coalesce into one pending event.
        evt_ready = 1'b0;
        press_key(9'h074);
        check_eq("stall_idx", evt_idx, 2'd1);
        check_eq("stall_rep0", evt_repeat, 1'b0);
        tick(19);
        check_eq("stall_valid", evt_valid, 1'b1);
        check_eq("stall_rep1", evt_repeat, 1'b1);
        check_eq("stall_drop", drop_cnt, 8'd3);
        evt_ready = 1'b1;
        tick(1);
        check_eq("setclr_valid", evt_valid, 1'b1);
        check_eq("setclr_idx", evt_idx, 2'd1);
        check_eq("setclr_drop", drop_cnt, 8'd3);

        // Disable clears the pending event but the slot keeps its phase.
        evt_ready = 1'b0;
        enable    = 1'b0;
        tick(1);
        check_eq("dis_valid", evt_valid, 1'b0);
        check_eq("dis_held", keyPressed, 4'b0010);
        evt_ready = 1'b1;
        tick(3);
        check_eq("dis_suppress", evt_valid, 1'b0);
        check_eq("dis_held2", keyPressed, 4'b0010);
        enable = 1'b1;
        tick(3);
        check_eq("en_gap", evt_valid, 1'b0);
        tick(1);
        check_eq("en_phase_valid", evt_valid, 1'b1);
        check_eq("en_phase_idx", evt_idx, 2'd1);
        check_eq("en_phase_rep", evt_repeat, 1'b1);
        break_key(9'h074);
        check_eq("en_released", keyPressed, 4'b0000);
        check_eq("en_idle", evt_valid, 1'b0);

        // Rebinding slot 3 replaces the old code.
        cfg_write(2'd3, 9'h01C);
        press_key(9'h01C);
        check_eq("cfg_valid", evt_valid, 1'b1);
        check_eq("cfg_idx", evt_idx, 2'd3);
        break_key(9'h01C);
        check_eq("cfg_taken", evt_valid, 1'b0);
        press_key(9'h075);
        check_eq("old_code_valid", evt_valid, 1'b0);
        check_eq("old_code_held", keyPressed, 4'b0000);

        // Asynchronous reset mid-run restores defaults.
        evt_ready = 1'b0;
        press_key(9'h074);
        tick(2);
        #3;
        resetN = 1'b0;
        #1;
        check_eq("arst_valid", evt_valid, 1'b0);
        check_eq("arst_held", keyPressed, 4'b0000);
        check_eq("arst_drop", drop_cnt, 8'd0);
        @(posedge clk);
        #1;
        resetN    = 1'b1;
        evt_ready = 1'b1;
        tick(1);
        press_key(9'h075);
        check_eq("arst_tbl_valid", evt_valid, 1'b1);
        check_eq("arst_tbl_idx", evt_idx, 2'd3);
        check_eq("arst_tbl_rep", evt_repeat, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits between the PS/2 keyboard front end (keyCode/make/brakee stream) and the game control logic.
- Holds a run-time programmable binding table of NUM_KEYS keycodes. Each bound key runs a typematic state machine that produces an initial-press event and then auto-repeat events.
- Pending events from all keys go through a round-robin arbiter onto a single valid/ready event channel, so player-control logic receives at most one action per handshake.

Parameters:
- NUM_KEYS, 4, number of binding slots (1..16)
- KEY_W, 9, keycode width, extended-code bit included
- INITIAL_DELAY, 25000000, clk cycles from press event to first repeat (0.5 s @ 50 MHz), >=2
- REPEAT_PERIOD, 5000000, clk cycles between repeats, >=2
- DEFAULT_CODES, {9'h06B,9'h074,9'h029,9'h075}, reset binding of slot i = DEFAULT_CODES[i]

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- keyCode  in  KEY_W  current keycode from PS/2 decoder
- make  in  1  one-cycle make strobe for keyCode
- brakee  in  1  one-cycle break strobe for keyCode
- enable  in  1  event generation enable
- cfg_we  in  1  binding-table write strobe
- cfg_idx  in  $clog2(NUM_KEYS)  slot to write
- cfg_code  in  KEY_W  new keycode for slot
- keyPressed  out  NUM_KEYS  per-slot held state
- evt_valid  out  1  event available
- evt_idx  out  $clog2(NUM_KEYS)  slot of the event
- evt_repeat  out  1  0 = initial press, 1 = auto-repeat
- evt_ready  in  1  consumer accepts event
- drop_cnt  out  8  saturating count of coalesced events

Behaviour:
- Reset values:
  - table[i] = DEFAULT_CODES[i]; all slots IDLE.
  - keyPressed, pending, pend_rep, grant lock, rr pointer, drop_cnt all 0; evt_valid = 0.
- Slot match: keyCode == table[i]. Several slots bound to one code all respond.
- Slot FSM (states IDLE, DELAY, REPEAT):
  - IDLE + make&match: go to DELAY, counter = INITIAL_DELAY-1, keyPressed[i] = 1, set pending[i] with pend_rep[i] = 0.
  - DELAY: counter decrements each cycle. At 0: go to REPEAT, counter = REPEAT_PERIOD-1, set pending[i] with pend_rep[i] = 1.
  - REPEAT: counter decrements. At 0: reload REPEAT_PERIOD-1, set pending[i] with pend_rep[i] = 1.
  - make&match in DELAY/REPEAT: ignored (keyboard typematic makes do not restart timing).
  - brakee&match in any state: go to IDLE, keyPressed[i] = 0, counter cleared. An already-pending event is still delivered.
  - make and brakee in the same cycle with match: brakee wins.
- Timing: a press event sets pending in the cycle after the make strobe; evt_valid rises that same cycle (1-cycle latency). First repeat is set INITIAL_DELAY cycles after the press pending; later repeats every REPEAT_PERIOD cycles.
- Coalescing: a set while pending[i] is already 1 keeps a single event, updates pend_rep[i] to the new type, and increments drop_cnt (saturates at 255). This applies only when the bit is not being cleared that cycle; see the set/clear rule below.
- Arbiter:
  - evt_valid = lock | (|pending). With no lock, the grant is the first pending slot at or after rr pointer, wrapping modulo NUM_KEYS.
  - evt_valid & !evt_ready: grant is locked. evt_idx/evt_repeat stay stable until the handshake, even if other bits become pending.
  - evt_valid & evt_ready: pending[evt_idx] cleared, rr = evt_idx+1 (wrap), lock released. The next event can be presented the following cycle.
  - Same-cycle set and clear on the granted slot: the set wins, the bit stays pending with its new type, and drop_cnt is not incremented.
- enable = 0:
  - No new pending bits are set; all pending bits and the lock are cleared; evt_valid = 0 next cycle.
  - Slot FSMs, counters and keyPressed keep running, so repeat phase is preserved when enable returns.
- cfg_we:
  - table[cfg_idx] = cfg_code next cycle; that slot goes to IDLE with keyPressed, pending and lock cleared if locked on it.
  - A make/break on the same cycle compares against the old code.
- Counter width: $clog2(max(INITIAL_DELAY,REPEAT_PERIOD)).
- resetN asserted mid-operation returns everything to reset values immediately (async).

Decomposition:
- Package key_sched_pkg:
  - slot_state_t enum {IDLE, DELAY, REPEAT}
  - KEY_W
  - default keycode constants (arrows 06B/074/075, space 029)
  - counter-width function
- Sub-module key_repeat_slot: one slot FSM, counter and match compare; outputs keyPressed, set_pend, set_rep. Instantiated NUM_KEYS times via generate.
- Top level holds the binding table, pending/pend_rep registers, round-robin arbiter, lock and drop_cnt.

Test Plan (INITIAL_DELAY=8, REPEAT_PERIOD=4, evt_ready=1 unless stated):
- Reset with resetN=0 mid-run -> all outputs 0, table back to defaults.
- make 9'h06B at cycle 0 -> evt_valid, evt_idx=0, evt_repeat=0 at cycle 1; repeat events at cycles 9, 13, 17; brakee at 15 -> no event at 17, keyPressed[0]=0.
- Slots 0 and 2 pressed in the same cycle with evt_ready=0 for 5 cycles -> evt_idx=0 held stable; then idx 0 then idx 2 on consecutive handshakes; rr wraps correctly.
- evt_ready=0 for 20 cycles while slot 1 is held -> single pending event with evt_repeat=1, drop_cnt=3.
- cfg_we idx=3 code=9'h01C, then make 9'h01C -> event idx 3; make 9'h075 -> no event.
- enable=0 while key held -> evt_valid=0, keyPressed stays 1; enable=1 -> repeats resume on the original 4-cycle phase.
